// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects an MSB-first bitstream into an MSB-aligned
// word and reports the bit count in the serializer's data_mod encoding (0 = full word).
module deserializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              deser_err_o
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    localparam logic [MOD_W:0] FULL  = (MOD_W+1)'(DATA_W);
    localparam logic [MOD_W:0] LAST  = (MOD_W+1)'(DATA_W - 1);
    localparam logic [MOD_W:0] MIN_K = (MOD_W+1)'(3);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [MOD_W:0]    cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state            <= IDLE;
            shift            <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            deser_err_o      <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            deser_err_o      <= 1'b0;
            if (ser_data_val_i) begin
                if (cnt == LAST) begin
                    // Last bit of a full word goes straight to the output so the
                    // next cycle can already start a new frame.
                    deser_data_o     <= {shift[DATA_W-2:0], ser_data_i};
                    deser_data_mod_o <= '0;
                    deser_data_val_o <= 1'b1;
                    shift            <= '0;
                    cnt              <= '0;
                    state            <= IDLE;
                end else begin
                    shift <= {shift[DATA_W-2:0], ser_data_i};
                    cnt   <= cnt + 1'b1;
                    state <= RECV;
                end
            end else if (state == RECV) begin
                // Shift register is cleared between frames, so only the k
                // received bits are non-zero and a plain shift aligns them.
                if (cnt >= MIN_K) begin
                    deser_data_o     <= shift << (FULL - cnt);
                    deser_data_mod_o <= cnt[MOD_W-1:0];
                    deser_data_val_o <= 1'b1;
                end else begin
                    deser_err_o <= 1'b1;
                end
                shift <= '0;
                cnt   <= '0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: a serializer model drives frames and queues the
// expected word, count, error flag and arrival cycle; a negedge monitor pops on pulses.
module tb_deserializer;

    logic        clk;
    logic        arst_n;
    logic        ser_data;
    logic        ser_data_val;
    logic [15:0] deser_data;
    logic [3:0]  deser_data_mod;
    logic        deser_data_val;
    logic        deser_err;

    deserializer #(.DATA_W(16), .MOD_W(4)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_data_val),
        .deser_data_o     (deser_data),
        .deser_data_mod_o (deser_data_mod),
        .deser_data_val_o (deser_data_val),
        .deser_err_o      (deser_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (arst_n && (deser_data_val || deser_err)) begin
            check("excl", {31'd0, deser_data_val & deser_err}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious", {30'd0, deser_data_val, deser_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lat", cyc, e.due);
                check("err", {31'd0, deser_err}, {31'd0, e.err});
                check("val", {31'd0, deser_data_val}, {31'd0, ~e.err});
                if (!e.err) begin
                    check("data", {16'd0, deser_data}, {16'd0, e.data});
                    check("mod", {28'd0, deser_data_mod}, {28'd0, e.mod});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the top n bits of w MSB first; terminates with an idle cycle when the
    // frame is partial or gap is set. push=0 leaves the frame unterminated and unqueued.
    task automatic send(input logic [15:0] w, input int unsigned n, input bit gap, input bit push);
        exp_t        e;
        logic [15:0] mask;
        mask   = 16'hFFFF << (16 - n);
        e.data = w & mask;
        e.mod  = (n == 16) ? 4'd0 : 4'(n);
        e.err  = (n < 3);
        for (int unsigned i = 0; i < n; i++) begin
            ser_data     = w[15-i];
            ser_data_val = 1'b1;
            if (push && n == 16 && i == 15) begin
                e.due = cyc + 1;
                sb.push_back(e);
            end
            step();
        end
        if (push && (gap || n < 16)) begin
            ser_data_val = 1'b0;
            ser_data     = 1'b0;
            if (n < 16) begin
                e.due = cyc + 1;
                sb.push_back(e);
            end
            step();
        end
    endtask

    task automatic idle(input int unsigned n);
        ser_data_val = 1'b0;
        ser_data     = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [15:0] w;
        int unsigned n;
        int unsigned m;

        arst_n       = 1'b0;
        ser_data     = 1'b0;
        ser_data_val = 1'b0;
        #12;
        check("rst_data", {16'd0, deser_data}, 32'd0);
        check("rst_mod", {28'd0, deser_data_mod}, 32'd0);
        check("rst_pulse", {30'd0, deser_data_val, deser_err}, 32'd0);
        #10;
        arst_n = 1'b1;
        step();
        idle(3);

        send(16'hA5C3, 16, 1'b1, 1'b1);
        idle(2);
        send(16'hB000, 5, 1'b1, 1'b1);
        idle(2);
        send(16'hFFFF, 16, 1'b0, 1'b1);
        send(16'h0001, 16, 1'b1, 1'b1);
        idle(2);
        send(16'h8000, 1, 1'b1, 1'b1);
        send(16'h4000, 2, 1'b1, 1'b1);
        send(16'hE000, 3, 1'b1, 1'b1);
        idle(2);
        send(16'h7FFF, 15, 1'b1, 1'b1);
        idle(2);

        // Mid-frame reset: partial frame must vanish without any pulse.
        send(16'hC300, 8, 1'b0, 1'b0);
        ser_data_val = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check("mid_rst_data", {16'd0, deser_data}, 32'd0);
        check("mid_rst_mod", {28'd0, deser_data_mod}, 32'd0);
        check("mid_rst_pulse", {30'd0, deser_data_val, deser_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("mid_rst_hold", {16'd0, deser_data}, 32'd0);
        arst_n = 1'b1;
        step();
        idle(2);
        send(16'h1234, 16, 1'b1, 1'b1);
        idle(2);

        for (int unsigned k = 0; k < 1000; k++) begin
            w = 16'($urandom);
            m = $urandom_range(0, 13);
            n = (m == 0) ? 16 : m + 2;
            send(w, n, ($urandom_range(0, 1) == 1), 1'b1);
        end
        idle(4);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
